activation_scheduler: RTL
=========================

// Module: activation_scheduler
// PURPOSE
//   Sequences one batch of NUM_NEURON pre-activation values through the shared, single-ported activation LUT BRAM.
//   Runs a start/ready/done handshake with the layer controller and collects the LUT results into a packed output vector.
//   Sits between the neuron accumulators and the activation BRAM. The BRAM itself is external; this block only drives it.
// PARAMETERS
//   NUM_NEURON     6   neurons per batch (>=1)
//   LUT_ADDR_SIZE  10  LUT address width = width of each input slot
//   LUT_WIDTH      9   LUT data width = width of each output slot
//   LUT_LATENCY    1   BRAM read latency in cycles (1..3)
// PORTS
//   clk        in   1                         clock, rising edge
//   rst        in   1                         asynchronous, active-low reset (asserted at 0)
//   start      in   1                         request a batch; accepted only when start && ready
//   ready      out  1                         high in IDLE only
//   inputs     in   NUM_NEURON*LUT_ADDR_SIZE  slot i = [i*LUT_ADDR_SIZE +: LUT_ADDR_SIZE]; sampled on accept
//   lut_rd_en  out  1                         BRAM read enable
//   lut_addr   out  LUT_ADDR_SIZE             BRAM read address
//   lut_data   in   LUT_WIDTH                 BRAM read data, valid LUT_LATENCY cycles after lut_rd_en
//   outputs    out  NUM_NEURON*LUT_WIDTH      slot i = activation of input slot i
//   done       out  1                         one-cycle pulse when the batch completes
//   stable     out  1                         outputs match the last accepted inputs; held until next accept
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; ready=1; lut_rd_en=0; lut_addr=0; outputs=0; done=0; stable=0.
//     All counters and the return pipe are cleared.
//   Reset mid-batch: aborts immediately. lut_rd_en drops without waiting for a clock edge, and in-flight returns are discarded.
//   FSM states: IDLE, ISSUE, DRAIN, DONE.
//     IDLE  -> ISSUE  on start && ready. Capture inputs into in_buf, clear stable, issue_cnt=0.
//     ISSUE -> DRAIN  after the issue with issue_cnt==NUM_NEURON-1.
//       Each cycle in ISSUE: lut_rd_en=1, lut_addr=in_buf slot issue_cnt, issue_cnt++.
//     DRAIN -> DONE   when the last return has been captured. lut_rd_en=0.
//     DONE  -> IDLE   unconditionally. done=1 and stable=1 for this cycle; stable stays 1 afterwards.
//   Return path: a valid+index tag travels a LUT_LATENCY-deep pipe alongside each read.
//     When the tag emerges, lut_data is written to outputs slot index.
//   Timing: accept at edge 0. Reads are issued in cycles 1..N. done is high in cycle N+LUT_LATENCY+1.
//     ready returns in cycle N+LUT_LATENCY+2. Example: N=6, L=1 gives done in cycle 8.
//   During a batch, output slots update progressively. They are valid only once done/stable is high.
//   start while ready=0 (ISSUE/DRAIN/DONE): ignored, not queued.
//   inputs may change freely after the accept cycle, because only in_buf is used.
//   N=1: ISSUE lasts exactly one cycle. Counters use clog2(NUM_NEURON)+1 bits and never wrap mid-batch.
// CONFIGURATION
//   ACT_CHANGE_DETECT_EN defined:
//     A last_in register (reset to all ones) holds the inputs of the last completed batch.
//     On accept with stable==1 and inputs==last_in: go IDLE->DONE directly.
//     In that case there are no reads, outputs are unchanged, and done is high in cycle 1.
//     last_in is updated on entry to DONE of a full batch.
//   ACT_CHANGE_DETECT_EN undefined:
//     Every accepted start runs the full ISSUE/DRAIN sequence. No last_in register is built.
// STRUCTURE
//   Package activation_sched_pkg holds:
//     the FSM state localparams (IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2, DONE=2'd3);
//     the clog2 function;
//     the LUT_LATENCY legal-range check.
//   Sub-module lut_return_pipe:
//     a parameterised LUT_LATENCY-deep shift register of {valid, index};
//     async active-low clear.
// TESTING
//   1 Reset: rst=0 mid-ISSUE -> lut_rd_en=0 immediately, outputs=0, ready=1, stable=0.
//     After release, the next start runs cleanly.
//   2 Basic batch: N=6, L=1, identity LUT, inputs {5,4,3,2,1,0}.
//     lut_addr = 0,1,2,3,4,5 in cycles 1..6; done in cycle 8; outputs slot i = i; stable=1.
//   3 Latency sweep: L=3, same stimulus -> done in cycle 10. No slot is overwritten by a stale return.
//   4 Ignored start: pulse start in cycles 2 and 8 -> neither is accepted. ready rises in cycle 9.
//     A start in cycle 9 is accepted.
//   5 Input hold: change inputs in cycle 1 -> addresses still come from the values captured at accept.
//   6 ACT_CHANGE_DETECT_EN: repeat an identical batch -> done in cycle 1, zero lut_rd_en pulses.
//     Change one slot -> full 6-read batch.

Source files
------------

// File: rtl/activation_sched_pkg.sv
// Shared types and helpers for the activation scheduler: FSM state encoding,
// a constant clog2 and the legal BRAM read-latency window.
package activation_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit latency_ok(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/lut_return_pipe.sv
// Tag pipe that travels alongside each LUT read: {valid, index} delayed by
// DEPTH cycles so the returning BRAM word knows which output slot it belongs to.
module lut_return_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      idx_q[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/activation_scheduler.sv
// Streams one batch of pre-activations through the shared activation LUT BRAM
// and gathers the results. Optional feature macro: ACT_CHANGE_DETECT_EN.
//
// Handshake: a batch is accepted on a rising edge where start && ready; ready is
// high only in IDLE, and start while not ready is dropped, never queued. done is
// a single-cycle pulse; stable then holds until the next accepted start.
module activation_scheduler
  import activation_sched_pkg::*;
#(
  parameter int NUM_NEURON    = 6,
  parameter int LUT_ADDR_SIZE = 10,
  parameter int LUT_WIDTH     = 9,
  parameter int LUT_LATENCY   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            ready,
  input  logic [NUM_NEURON*LUT_ADDR_SIZE-1:0] inputs,
  output logic                            lut_rd_en,
  output logic [LUT_ADDR_SIZE-1:0]        lut_addr,
  input  logic [LUT_WIDTH-1:0]            lut_data,
  output logic [NUM_NEURON*LUT_WIDTH-1:0] outputs,
  output logic                            done,
  output logic                            stable,
  output sched_state_t                    state_dbg
);

  localparam int CW = clog2(NUM_NEURON) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_NEURON - 1);

  if (!latency_ok(LUT_LATENCY)) begin : g_bad_latency
    $error("activation_scheduler: LUT_LATENCY out of range");
  end

  sched_state_t                        state, next_state;
  logic [NUM_NEURON*LUT_ADDR_SIZE-1:0] in_buf;
  logic [CW-1:0]                       issue_cnt;
  logic                                tag_valid;
  logic [CW-1:0]                       tag_idx;
  logic                                accept;
  logic                                skip;
  logic                                last_return;

  assign ready       = (state == IDLE);
  assign accept      = start && ready;
  assign lut_rd_en   = (state == ISSUE);
  assign done        = (state == DONE);
  assign state_dbg   = state;
  assign last_return = tag_valid && (tag_idx == LAST_IDX);

`ifdef ACT_CHANGE_DETECT_EN
  // Inputs of the last fully processed batch; all ones so nothing matches after reset.
  logic [NUM_NEURON*LUT_ADDR_SIZE-1:0] last_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_in <= '1;
    end else if (state == DRAIN && next_state == DONE) begin
      last_in <= in_buf;
    end
  end

  assign skip = stable && (inputs == last_in);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = skip ? DONE : ISSUE;
      ISSUE:   if (issue_cnt == LAST_IDX) next_state = DRAIN;
      DRAIN:   if (last_return) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Address comes from the captured copy, never the live inputs bus.
  always_comb begin
    lut_addr = '0;
    if (state == ISSUE) begin
      for (int i = 0; i < NUM_NEURON; i++) begin
        if (issue_cnt == CW'(i)) lut_addr = in_buf[i*LUT_ADDR_SIZE +: LUT_ADDR_SIZE];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_buf    <= '0;
      issue_cnt <= '0;
      stable    <= 1'b0;
    end else begin
      if (accept) begin
        in_buf    <= inputs;
        issue_cnt <= '0;
      end else if (state == ISSUE) begin
        issue_cnt <= issue_cnt + CW'(1);
      end
      if (state != DONE && next_state == DONE) stable <= 1'b1;
      else if (accept)                         stable <= 1'b0;
    end
  end

  lut_return_pipe #(
    .DEPTH (LUT_LATENCY),
    .IDX_W (CW)
  ) u_ret_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (lut_rd_en),
    .in_idx    (issue_cnt),
    .out_valid (tag_valid),
    .out_idx   (tag_idx)
  );

  // Slots fill progressively as their tags emerge from the pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outputs <= '0;
    end else if (tag_valid) begin
      for (int i = 0; i < NUM_NEURON; i++) begin
        if (tag_idx == CW'(i)) outputs[i*LUT_WIDTH +: LUT_WIDTH] <= lut_data;
      end
    end
  end

endmodule
